// File: rtl/fir_sample_feeder_if.sv
// Sample-stream and FIR-side handshake bundle for fir_sample_feeder.
// The feeder takes the slave view; the upstream source and the FIR take the master view.
interface fir_sample_feeder_if #(
  parameter int unsigned DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] fir_in;
  logic                  fir_input_valid;
  logic                  fir_output_valid;

  modport slave (
    input  s_data,
    input  s_valid,
    input  fir_output_valid,
    output s_ready,
    output fir_in,
    output fir_input_valid
  );

  modport master (
    output s_data,
    output s_valid,
    output fir_output_valid,
    input  s_ready,
    input  fir_in,
    input  fir_input_valid
  );
endinterface

// File: rtl/fir_sample_feeder.sv
// Buffers a valid/ready sample stream in a FIFO and issues one sample at a time to the FIR,
// waiting for its completion edge; a watchdog recovers from a lost completion.
module fir_sample_feeder #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  fir_sample_feeder_if.slave     bus,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy,
  output logic                   timeout_err,
  input  logic                   clr_err
);

  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned WdogW = $clog2(TIMEOUT + 1);
  localparam logic [PtrW:0]    LevelFull = (PtrW + 1)'(DEPTH);
  localparam logic [WdogW-1:0] WdogLast  = WdogW'(TIMEOUT - 1);

  typedef enum logic {StIdle, StWait} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]         level_q;
  logic [WdogW-1:0]      wdog_q;
  logic [DATA_WIDTH-1:0] fir_in_q;
  logic                  fir_input_valid_q;
  logic                  fir_output_valid_q;
  logic                  timeout_err_q;

  logic push, pop, done, wdog_expired, timeout;

  // s_ready depends only on registered occupancy, so a full FIFO never accepts.
  assign bus.s_ready = (level_q != LevelFull);
  assign push        = bus.s_valid && bus.s_ready;
  assign done        = bus.fir_output_valid && !fir_output_valid_q;
  assign wdog_expired = (wdog_q == WdogLast);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (level_q != '0) state_d = StWait;
      StWait: if (done || wdog_expired) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy    = (state_q == StWait);
    pop     = (state_q == StIdle) && (level_q != '0);
    // A completion on the expiry cycle wins over the watchdog.
    timeout = (state_q == StWait) && !done && wdog_expired;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= bus.s_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q           <= '0;
      rd_ptr_q           <= '0;
      level_q            <= '0;
      wdog_q             <= '0;
      fir_in_q           <= '0;
      fir_input_valid_q  <= 1'b0;
      fir_output_valid_q <= 1'b0;
      timeout_err_q      <= 1'b0;
    end else begin
      fir_output_valid_q <= bus.fir_output_valid;
      fir_input_valid_q  <= pop;

      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        fir_in_q <= mem[rd_ptr_q];
      end

      if (push && !pop) begin
        level_q <= level_q + 1'b1;
      end else if (pop && !push) begin
        level_q <= level_q - 1'b1;
      end

      if (pop) begin
        wdog_q <= '0;
      end else if (state_q == StWait) begin
        wdog_q <= wdog_q + 1'b1;
      end

      if (timeout) begin
        timeout_err_q <= 1'b1;
      end else if (clr_err) begin
        timeout_err_q <= 1'b0;
      end
    end
  end

  assign bus.fir_in          = fir_in_q;
  assign bus.fir_input_valid = fir_input_valid_q;
  assign level               = level_q;
  assign timeout_err         = timeout_err_q;

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Self-checking bench for fir_sample_feeder: stub FIR, behavioural queue model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fir_sample_feeder;

  localparam int DW      = 16;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr_err = 1'b0;
  logic [3:0] level;
  logic busy;
  logic timeout_err;

  fir_sample_feeder_if #(.DATA_WIDTH(DW)) bus ();

  fir_sample_feeder #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .level      (level),
    .busy       (busy),
    .timeout_err(timeout_err),
    .clr_err    (clr_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stub FIR: completion stub_lat cycles after each pulse (0 = never), held for stub_hold_len.
  int stub_lat = 131;
  int stub_hold_len = 1;
  int stub_cnt = 0;
  int stub_hold = 0;

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      stub_cnt = 0;
      stub_hold = 0;
      bus.fir_output_valid = 1'b0;
    end else begin
      if (bus.fir_input_valid === 1'b1) begin
        stub_cnt = stub_lat;
      end else if (stub_cnt > 1) begin
        stub_cnt--;
      end else if (stub_cnt == 1) begin
        stub_cnt = 0;
        stub_hold = stub_hold_len;
      end
      bus.fir_output_valid = (stub_hold > 0);
      if (stub_hold > 0) stub_hold--;
    end
  end

  // Issue log for ordering checks.
  logic [DW-1:0] log_q[$];
  always @(negedge clk) begin
    if (bus.fir_input_valid === 1'b1) log_q.push_back(bus.fir_in);
  end

  // Behavioural model: a sample queue plus "waiting for FIR" with elapsed-cycle count.
  logic [DW-1:0] mq[$];
  bit            m_wait;
  int            m_cnt;
  logic [DW-1:0] m_fin;
  bit            m_iv;
  bit            m_err;
  bit            m_fov;
  bit            m_push, m_done, m_tmo;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_wait = 0; m_cnt = 0; m_fin = '0; m_iv = 0; m_err = 0; m_fov = 0;
    end else begin
      m_push = (bus.s_valid === 1'b1) && (mq.size() < DEPTH);
      m_done = (bus.fir_output_valid === 1'b1) && !m_fov;
      m_tmo  = 0;
      m_iv   = 0;
      if (!m_wait) begin
        if (mq.size() > 0) begin
          m_fin  = mq.pop_front();
          m_iv   = 1;
          m_wait = 1;
          m_cnt  = 0;
        end
      end else begin
        m_cnt++;
        if (m_done) m_wait = 0;
        else if (m_cnt == TIMEOUT) begin
          m_wait = 0;
          m_tmo  = 1;
        end
      end
      if (m_tmo) m_err = 1;
      else if (clr_err) m_err = 0;
      if (m_push) mq.push_back(bus.s_data);
      m_fov = (bus.fir_output_valid === 1'b1);
    end
  end

  always @(negedge clk) begin
    chk("s_ready", 32'(bus.s_ready), 32'(mq.size() != DEPTH));
    chk("level", 32'(level), 32'(mq.size()));
    chk("fir_in", 32'(bus.fir_in), 32'(m_fin));
    chk("fir_input_valid", 32'(bus.fir_input_valid), 32'(m_iv));
    chk("busy", 32'(busy), 32'(m_wait));
    chk("timeout_err", 32'(timeout_err), 32'(m_err));
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] v);
    int n = 0;
    bus.s_data  = v;
    bus.s_valid = 1'b1;
    while (!bus.s_ready && n < 1000) begin
      step();
      n++;
    end
    step();
    bus.s_valid = 1'b0;
    chk("push_wait_bound", 32'(n < 1000), 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((level != 0 || busy) && n < 5000) begin
      step();
      n++;
    end
    step();
    chk("wait_idle_bound", 32'(n < 5000), 32'd1);
  endtask

  task automatic check_log(input string name, input logic [DW-1:0] exp[$]);
    chk({name, "_count"}, 32'(log_q.size()), 32'(exp.size()));
    foreach (exp[i]) begin
      if (i < log_q.size()) chk(name, 32'(log_q[i]), 32'(exp[i]));
    end
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
  endtask

  logic [DW-1:0] exp_q[$];
  int k;

  initial begin
    bus.s_data  = '0;
    bus.s_valid = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Single sample latency and completion.
    stub_lat = 131;
    push(16'h0125);
    chk("t2_level_after_push", 32'(level), 32'd1);
    chk("t2_no_issue_yet", 32'(bus.fir_input_valid), 32'd0);
    step();
    chk("t2_issue_valid", 32'(bus.fir_input_valid), 32'd1);
    chk("t2_issue_data", 32'(bus.fir_in), 32'h0125);
    chk("t2_busy", 32'(busy), 32'd1);
    step();
    chk("t2_pulse_one_cycle", 32'(bus.fir_input_valid), 32'd0);
    k = 0;
    while (!bus.fir_output_valid && k < 300) begin
      step();
      k++;
    end
    chk("t2_done_bound", 32'(k < 300), 32'd1);
    chk("t2_busy_at_done", 32'(busy), 32'd1);
    step();
    chk("t2_busy_after_done", 32'(busy), 32'd0);
    chk("t2_fir_in_retained", 32'(bus.fir_in), 32'h0125);

    // Fill under a stalled FIR, then drain across the pointer wrap.
    stub_lat = 0;
    log_q.delete();
    for (int i = 1; i <= 9; i++) push(DW'(i));
    chk("t3_level_full", 32'(level), 32'd8);
    chk("t3_s_ready_full", 32'(bus.s_ready), 32'd0);
    stub_lat = 5;
    push(16'h000A);
    wait_idle();
    exp_q.delete();
    for (int i = 1; i <= 10; i++) exp_q.push_back(DW'(i));
    check_log("t3_order", exp_q);

    // Push and issue on the same edge with level 3.
    pulse_clr();
    stub_lat = 20;
    log_q.delete();
    push(16'h00A1);
    push(16'h00B2);
    push(16'h00C3);
    push(16'h00D4);
    k = 0;
    while (busy && k < 200) begin
      step();
      k++;
    end
    chk("t4_idle_bound", 32'(k < 200), 32'd1);
    chk("t4_level_before", 32'(level), 32'd3);
    bus.s_data  = 16'h00E5;
    bus.s_valid = 1'b1;
    step();
    bus.s_valid = 1'b0;
    chk("t4_level_same", 32'(level), 32'd3);
    chk("t4_issue", 32'(bus.fir_input_valid), 32'd1);
    chk("t4_issue_data", 32'(bus.fir_in), 32'h00B2);
    wait_idle();
    exp_q = '{16'h00A1, 16'h00B2, 16'h00C3, 16'h00D4, 16'h00E5};
    check_log("t4_order", exp_q);

    // Watchdog: expiry timing, clear, and set-beats-clear.
    stub_lat = 0;
    push(16'h1111);
    push(16'h2222);
    chk("t5_issue_x1", 32'(bus.fir_in), 32'h1111);
    k = 0;
    while (!timeout_err && k < 400) begin
      step();
      k++;
    end
    chk("t5_timeout_cycles", 32'(k), 32'd255);
    step();
    chk("t5_next_issue", 32'(bus.fir_input_valid), 32'd1);
    chk("t5_next_data", 32'(bus.fir_in), 32'h2222);
    pulse_clr();
    chk("t5_err_cleared", 32'(timeout_err), 32'd0);
    repeat (253) step();
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("t5_set_beats_clear", 32'(timeout_err), 32'd1);

    // Asynchronous reset mid-cycle during WAIT with level 5.
    pulse_clr();
    for (int i = 0; i < 6; i++) push(DW'(16'h0300 + i));
    chk("t6_level5", 32'(level), 32'd5);
    chk("t6_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t1_s_ready", 32'(bus.s_ready), 32'd1);
    chk("t1_level", 32'(level), 32'd0);
    chk("t1_fir_in", 32'(bus.fir_in), 32'd0);
    chk("t1_fir_input_valid", 32'(bus.fir_input_valid), 32'd0);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_timeout_err", 32'(timeout_err), 32'd0);
    step();
    rst = 1'b0;
    log_q.delete();
    repeat (20) step();
    chk("t6_no_issue_after_rst", 32'(log_q.size()), 32'd0);
    stub_lat = 131;
    push(16'h0125);
    push(16'h0E11);
    push(16'h089D);
    wait_idle();
    exp_q = '{16'h0125, 16'h0E11, 16'h089D};
    check_log("t6_order", exp_q);

    // Randomized traffic with varying FIR latency, held completions and lost completions.
    for (int c = 0; c < 4000; c++) begin
      if (c % 150 == 0) begin
        stub_lat      = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 40));
        stub_hold_len = int'($urandom_range(1, 3));
      end
      bus.s_valid = ($urandom_range(0, 2) != 0);
      bus.s_data  = DW'($urandom);
      clr_err     = ($urandom_range(0, 49) == 0);
      step();
    end
    bus.s_valid   = 1'b0;
    clr_err       = 1'b0;
    stub_lat      = 3;
    stub_hold_len = 1;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
